// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle between the requesters, the port arbiter and sdram_controller.
// The arbiter uses the master view; requesters and controller sit on the slave view.
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 128
);
    logic                          iinit_done;
    logic [NUM_PORTS-1:0]          ireq;
    logic [NUM_PORTS-1:0]          iwe;
    logic [NUM_PORTS*ADDR_W-1:0]   iaddr;
    logic [NUM_PORTS*DATA_W-1:0]   iwdata;
    logic [NUM_PORTS-1:0]          oack;
    logic [NUM_PORTS-1:0]          oerr;
    logic [DATA_W-1:0]             ordata;
    logic                          obusy;
    logic                          owrite_req;
    logic [ADDR_W-1:0]             owrite_address;
    logic [DATA_W-1:0]             owrite_data;
    logic                          iwrite_ack;
    logic                          oread_req;
    logic [ADDR_W-1:0]             oread_address;
    logic [DATA_W-1:0]             iread_data;
    logic                          iread_ack;

    modport master (
        input  iinit_done, ireq, iwe, iaddr, iwdata,
        input  iwrite_ack, iread_data, iread_ack,
        output oack, oerr, ordata, obusy,
        output owrite_req, owrite_address, owrite_data,
        output oread_req, oread_address
    );

    modport slave (
        output iinit_done, ireq, iwe, iaddr, iwdata,
        output iwrite_ack, iread_data, iread_ack,
        input  oack, oerr, ordata, obusy,
        input  owrite_req, owrite_address, owrite_data,
        input  oread_req, oread_address
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one sdram_controller request interface among NUM_PORTS
// requesters, one outstanding transaction at a time, with a hung-transaction timeout.
module sdram_port_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 iclk,
    input  logic                 ireset,
    sdram_port_arbiter_if.master bus
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RELEASE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PORT_W-1:0]   last_q;
    logic [PORT_W-1:0]   port_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_PORTS-1:0] ack_q;
    logic [NUM_PORTS-1:0] err_q;

    logic [PORT_W-1:0]   pick;
    logic                pick_valid;
    logic                grant;
    logic                match_ack;
    logic                timeout_hit;

    // Search starts just after the last served port, so every requester gets a turn.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!pick_valid && bus.ireq[(int'(last_q) + i) % NUM_PORTS]) begin
                pick       = PORT_W'((int'(last_q) + i) % NUM_PORTS);
                pick_valid = 1'b1;
            end
        end
    end

    assign grant       = bus.iinit_done && pick_valid;
    assign match_ack   = we_q ? bus.iwrite_ack : bus.iread_ack;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant) state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: if (match_ack || timeout_hit) state_nxt = RELEASE;
            // A long ack level must fall before the next grant so it is never counted twice.
            RELEASE:  if (!bus.iwrite_ack && !bus.iread_ack) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (ireset) begin
            state   <= IDLE;
            last_q  <= PORT_W'(NUM_PORTS - 1);
            port_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state <= state_nxt;
            ack_q <= '0;
            err_q <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        port_q  <= pick;
                        we_q    <= bus.iwe[pick];
                        addr_q  <= bus.iaddr[pick*ADDR_W +: ADDR_W];
                        wdata_q <= bus.iwdata[pick*DATA_W +: DATA_W];
                    end
                end
                ISSUE: cnt_q <= '0;
                WAIT_ACK: begin
                    if (match_ack) begin
                        ack_q[port_q] <= 1'b1;
                        last_q        <= port_q;
                        if (!we_q) rdata_q <= bus.iread_data;
                    end else if (timeout_hit) begin
                        err_q[port_q] <= 1'b1;
                        last_q        <= port_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and data stay on the latched values until the next grant.
    assign bus.owrite_req     = (state == ISSUE) && we_q;
    assign bus.oread_req      = (state == ISSUE) && !we_q;
    assign bus.owrite_address = addr_q;
    assign bus.oread_address  = addr_q;
    assign bus.owrite_data    = wdata_q;
    assign bus.obusy          = (state != IDLE);
    assign bus.oack           = ack_q;
    assign bus.oerr           = err_q;
    assign bus.ordata         = rdata_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios followed by random traffic, all judged
// by a transaction-level reference model of grants, completions and timeouts.
module tb_sdram_port_arbiter;
    localparam int NP    = 2;
    localparam int AW    = 22;
    localparam int DW    = 128;
    localparam int TO    = 16;
    localparam int NEVER = 1 << 30;
    localparam logic [DW-1:0] PAT = 128'hDEADBEEFCAFEBABE123456789ABCDEF0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .iclk   (clk),
        .ireset (rst),
        .bus    (bus)
    );

    // Stimulus driven by requesters and the controller stand-in
    logic [NP-1:0] req, we;
    logic [AW-1:0] addr [NP];
    logic [DW-1:0] wdata [NP];
    logic          init, wack, rack;
    logic [DW-1:0] rdata;

    always_comb begin
        bus.ireq       = req;
        bus.iwe        = we;
        bus.iinit_done = init;
        bus.iwrite_ack = wack;
        bus.iread_ack  = rack;
        bus.iread_data = rdata;
        for (int p = 0; p < NP; p++) begin
            bus.iaddr[p*AW +: AW]  = addr[p];
            bus.iwdata[p*DW +: DW] = wdata[p];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction at a time, timing expressed in negedge indices
    int            nedge = 0;
    bit            m_busy, m_we, m_ok;
    int            m_issue, m_done_at, m_idle_from, m_port, m_last;
    int            m_k, m_len, m_spur;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata_exp, m_rdata_ret;
    int            done_cnt = 0;

    // Knobs steering requesters and controller behaviour
    bit            auto_req = 0, rand_ack = 0, init_flip = 0;
    int            req_pct = 0, fix_k = 1, fix_len = 1, fix_spur = 0;
    logic [DW-1:0] fix_rdata = PAT;

    // What the DUT was actually seen doing
    int obs_port[$];
    int obs_issue_edge = -1, obs_err_edge = -1, obs_ack_total = 0, obs_err_total = 0;

    function automatic int rr_pick(input int last, input logic [NP-1:0] r);
        for (int i = 1; i <= NP; i++) begin
            if (r[(last + i) % NP]) return (last + i) % NP;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic raise(input int p);
        req[p]   = 1'b1;
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = AW'($urandom());
        wdata[p] = rand_word();
    endtask

    task automatic plan_ack();
        if (rand_ack) begin
            int r = $urandom_range(99);
            if (r < 80)      m_k = $urandom_range(1, 6);
            else if (r < 88) m_k = TO;
            else if (r < 94) m_k = $urandom_range(TO + 1, TO + 3);
            else             m_k = 0;
            m_len  = $urandom_range(1, 3);
            m_spur = 0;
            if ($urandom_range(99) < 25) begin
                if (m_k == 0 || m_k > TO) m_spur = $urandom_range(1, TO);
                else if (m_k >= 2)        m_spur = $urandom_range(1, m_k - 1);
            end
            m_rdata_ret = rand_word();
        end else begin
            m_k         = fix_k;
            m_len       = fix_len;
            m_spur      = fix_spur;
            m_rdata_ret = fix_rdata;
        end
    endtask

    task automatic tick();
        logic [NP-1:0] prev_req, exp_ack, exp_err;
        logic          prev_init;
        logic [1:0]    exp_req;
        bit            was_idle, hit, sp;
        prev_req  = req;
        prev_init = init;
        @(negedge clk);
        nedge++;
        exp_ack  = '0;
        exp_err  = '0;
        exp_req  = '0;
        was_idle = !m_busy;
        if (m_busy && nedge == m_idle_from) m_busy = 0;
        if (was_idle && prev_init && |prev_req) begin
            m_port      = rr_pick(m_last, prev_req);
            m_we        = we[m_port];
            m_addr      = addr[m_port];
            m_wdata     = wdata[m_port];
            m_issue     = nedge;
            m_busy      = 1;
            m_idle_from = NEVER;
            plan_ack();
            m_ok        = (m_k >= 1 && m_k <= TO);
            m_done_at   = m_ok ? m_issue + m_k + 1 : m_issue + TO + 1;
            exp_req     = m_we ? 2'b10 : 2'b01;
        end
        if (m_busy && nedge == m_done_at) begin
            if (m_ok) begin
                exp_ack[m_port] = 1'b1;
                if (!m_we) m_rdata_exp = m_rdata_ret;
            end else begin
                exp_err[m_port] = 1'b1;
            end
            m_last = m_port;
            done_cnt++;
        end

        for (int p = 0; p < NP; p++) begin
            if (bus.oack[p]) begin obs_port.push_back(p); obs_ack_total++; end
            if (bus.oerr[p]) begin obs_port.push_back(p); obs_err_total++; obs_err_edge = nedge; end
        end
        if (bus.owrite_req || bus.oread_req) obs_issue_edge = nedge;

        check("req", {bus.owrite_req, bus.oread_req}, exp_req);
        check("ack", bus.oack, exp_ack);
        check("err", bus.oerr, exp_err);
        check("busy", bus.obusy, m_busy);
        check("ordata", bus.ordata, m_rdata_exp);
        check("waddr", bus.owrite_address, m_addr);
        check("raddr", bus.oread_address, m_addr);
        check("wdata", bus.owrite_data, m_wdata);

        // Requesters: drop after completion, optionally re-request or abandon mid-flight
        if (nedge == m_done_at) req[m_port] = 1'b0;
        if (auto_req) begin
            for (int p = 0; p < NP; p++) begin
                if (m_busy && p == m_port) begin
                    if (req_pct < 100 && req[p] && nedge < m_done_at && $urandom_range(99) < 5)
                        req[p] = 1'b0;
                end else if (!req[p] && $urandom_range(99) < req_pct) begin
                    raise(p);
                end
            end
        end
        if (init_flip && $urandom_range(99) < 3) init = ~init;

        // Controller stand-in: matching ack per plan, optional wrong-direction ack
        hit   = (m_k > 0) && (nedge >= m_issue + m_k) && (nedge < m_issue + m_k + m_len);
        sp    = (m_spur > 0) && (nedge == m_issue + m_spur);
        wack  = m_we ? hit : sp;
        rack  = m_we ? sp : hit;
        rdata = (hit && !m_we) ? m_rdata_ret : rand_word();
        if (m_busy && nedge >= m_done_at && m_idle_from == NEVER && !wack && !rack)
            m_idle_from = nedge + 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("txn_budget", done_cnt >= target, 1);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        wack = 1'b0;
        rack = 1'b0;
        @(negedge clk);
        nedge++;
        check("rst_ctl", {bus.oack, bus.oerr, bus.obusy, bus.owrite_req, bus.oread_req}, '0);
        check("rst_ordata", bus.ordata, '0);
        check("rst_addr", {bus.owrite_address, bus.oread_address}, '0);
        check("rst_wdata", bus.owrite_data, '0);
        @(negedge clk);
        nedge++;
        rst         = 1'b0;
        m_busy      = 0;
        m_last      = NP - 1;
        m_addr      = '0;
        m_wdata     = '0;
        m_rdata_exp = '0;
        m_k         = 0;
        m_spur      = 0;
        m_issue     = -1000;
        m_done_at   = -1;
        m_idle_from = NEVER;
    endtask

    initial begin
        int tgt, acks_before, errs_before, issue_before, n;
        init  = 1'b0;
        req   = '0;
        we    = '0;
        wack  = 1'b0;
        rack  = 1'b0;
        rdata = '0;
        for (int p = 0; p < NP; p++) begin
            addr[p]  = '0;
            wdata[p] = '0;
        end
        do_reset();

        // Requests while the controller is still initialising are never granted
        req = 2'b11;
        run(50);

        // Port 0 write, acked one cycle after the request
        req      = '0;
        init     = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 22'h000001;
        wdata[0] = PAT;
        req      = 2'b01;
        tgt      = done_cnt + 1;
        run_until(tgt, 40);
        run(4);
        check("t2_ack_port", obs_port[$], 0);

        // Port 1 reads the same word back
        we[1]     = 1'b0;
        addr[1]   = 22'h000001;
        wdata[1]  = rand_word();
        fix_rdata = PAT;
        req       = 2'b10;
        tgt       = done_cnt + 1;
        run_until(tgt, 40);
        run(4);
        check("t3_ack_port", obs_port[$], 1);
        check("t3_ordata", bus.ordata, PAT);

        // Both ports requesting continuously from reset alternate 0,1,0,1
        do_reset();
        obs_port.delete();
        auto_req = 1;
        req_pct  = 100;
        fix_k    = 2;
        raise(0);
        raise(1);
        tgt = done_cnt + 4;
        run_until(tgt, 200);
        auto_req = 0;
        req      = '0;
        run(TO + 10);
        for (int i = 0; i < 4; i++) check("t4_rr_order", obs_port[i], i % 2);

        // Read never acked, spurious write ack mid-wait: timeout then next grant proceeds
        we[0]    = 1'b0;
        addr[0]  = 22'h00002A;
        fix_k    = 0;
        fix_spur = 3;
        req      = 2'b01;
        tgt      = done_cnt + 1;
        run_until(tgt, TO + 20);
        run(4);
        check("t5_err_port", obs_port[$], 0);
        // oerr appears TO cycles after WAIT_ACK entry, which follows the request cycle
        check("t5_timeout_latency", obs_err_edge - obs_issue_edge, TO + 1);
        check("t5_ordata_kept", bus.ordata, PAT);
        fix_k    = 1;
        fix_spur = 0;
        we[1]    = 1'b1;
        addr[1]  = 22'h3FFFFF;
        wdata[1] = rand_word();
        req      = 2'b10;
        tgt      = done_cnt + 1;
        run_until(tgt, 40);
        run(4);
        check("t5_next_grant", obs_port[$], 1);

        // Three-cycle ack level yields exactly one oack
        acks_before = obs_ack_total;
        fix_len     = 3;
        we[0]       = 1'b1;
        addr[0]     = 22'h155555;
        wdata[0]    = rand_word();
        req         = 2'b01;
        tgt         = done_cnt + 1;
        run_until(tgt, 40);
        run(6);
        check("t6_single_ack", obs_ack_total - acks_before, 1);

        // Reset in the middle of WAIT_ACK drops the transaction silently
        fix_k        = 0;
        fix_len      = 1;
        we[1]        = 1'b0;
        addr[1]      = 22'h0000FF;
        req          = 2'b10;
        issue_before = obs_issue_edge;
        n            = 0;
        while (obs_issue_edge == issue_before && n < 20) begin
            tick();
            n++;
        end
        check("t6_issue_seen", obs_issue_edge != issue_before, 1);
        run(3);
        acks_before = obs_ack_total;
        errs_before = obs_err_total;
        do_reset();
        run(30);
        check("t6_silent_drop", (obs_ack_total - acks_before) + (obs_err_total - errs_before), 0);

        // Random traffic against the model
        auto_req  = 1;
        req_pct   = 30;
        rand_ack  = 1;
        init_flip = 1;
        tgt       = done_cnt + 300;
        run_until(tgt, 20000);
        auto_req  = 0;
        init_flip = 0;
        init      = 1'b1;
        req       = '0;
        run(TO + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
